fb_rect_fill: RTL

Framebuffer rectangle-fill engine. It sits directly upstream of the 135×240, 24-bit display framebuffer BRAM and drives that BRAM's write port (addr, wdata, sel, we). It accepts one rectangle command at a time over a valid/ready handshake, then normalizes, clips and rasterizes it row by row into framebuffer write cycles. An external arbiter shares the single BRAM address port with the SPI-LCD read side through `fb_gnt`.

---
 rtl/fb_rect_fill.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: normalizes, clips and rasterizes one rectangle command into framebuffer writes.
// Define FB_FILL_BYTE_SEL_EN to add the cmd_sel byte-enable input (fb_sel otherwise all ones).
module fb_rect_fill #(
   parameter int WIDTH  = 135,
   parameter int HEIGHT = 240,
   parameter int DW     = 24,
   parameter int MW     = DW/8,
   parameter int AW     = $clog2(WIDTH*HEIGHT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [7:0]    cmd_x0,
   input  logic [7:0]    cmd_y0,
   input  logic [7:0]    cmd_x1,
   input  logic [7:0]    cmd_y1,
   input  logic [DW-1:0] cmd_color,
`ifdef FB_FILL_BYTE_SEL_EN
   input  logic [MW-1:0] cmd_sel,
`endif
   input  logic          fb_gnt,
   output logic [AW-1:0] fb_addr,
   output logic [DW-1:0] fb_wdata,
   output logic [MW-1:0] fb_sel,
   output logic          fb_we,
   output logic          busy,
   output logic          done
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_FILL  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [7:0] XM = 8'(WIDTH-1);
   localparam logic [7:0] YM = 8'(HEIGHT-1);
   localparam logic [AW-1:0] WA = AW'(WIDTH);

   logic [1:0]    state;
   logic [7:0]    x0_q, y0_q, x1_q, y1_q;
   logic [7:0]    xmin, xmax, ymax, x, y;
   logic [DW-1:0] color;
   logic [AW-1:0] row_base;
   logic [7:0]    nxmin, nxmax, nymin, nymax;
   logic          empty;

   // Normalization and clipping of the latched corners, consumed in SETUP
   always_comb begin
      nxmin = (x0_q < x1_q) ? x0_q : x1_q;
      nxmax = (x0_q < x1_q) ? x1_q : x0_q;
      nymin = (y0_q < y1_q) ? y0_q : y1_q;
      nymax = (y0_q < y1_q) ? y1_q : y0_q;
      nxmax = (nxmax > XM) ? XM : nxmax;
      nymax = (nymax > YM) ? YM : nymax;
      empty = (nxmin > XM) || (nymin > YM);
   end

   assign cmd_ready = state == S_IDLE;
   assign busy      = state != S_IDLE;
   assign done      = state == S_DONE;
   assign fb_we     = (state == S_FILL) && fb_gnt && !rst;
   assign fb_addr   = row_base + AW'(x);
   assign fb_wdata  = color;

`ifdef FB_FILL_BYTE_SEL_EN
   logic [MW-1:0] sel_q;
   always_ff @(posedge clk)
      if (rst) sel_q <= '1;
      else if (cmd_valid && cmd_ready) sel_q <= cmd_sel;
   assign fb_sel = (state == S_FILL) ? sel_q : '1;
`else
   assign fb_sel = '1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         color    <= '0;
         xmin     <= '0;
         xmax     <= '0;
         ymax     <= '0;
         x        <= '0;
         y        <= '0;
         row_base <= '0;
      end else begin
         case (state)
            S_IDLE:
               if (cmd_valid) begin
                  x0_q  <= cmd_x0;
                  y0_q  <= cmd_y0;
                  x1_q  <= cmd_x1;
                  y1_q  <= cmd_y1;
                  color <= cmd_color;
                  state <= S_SETUP;
               end
            S_SETUP: begin
               xmin     <= nxmin;
               xmax     <= nxmax;
               ymax     <= nymax;
               x        <= nxmin;
               y        <= nymin;
               row_base <= AW'(nymin) * WA;
               state    <= empty ? S_DONE : S_FILL;
            end
            S_FILL:
               if (fb_gnt) begin
                  if (x < xmax) x <= x + 8'd1;
                  else if (y < ymax) begin
                     x        <= xmin;
                     y        <= y + 8'd1;
                     row_base <= row_base + WA;
                  end else state <= S_DONE;
               end
            S_DONE: state <= S_IDLE;
         endcase
      end
   end
endmodule
